// File: rtl/prio_enc_queue_if.sv
// Request/index handshake bundle for prio_enc_queue; master drives requests and ready.
// The mask line exists only when PRIO_ENC_MASK_EN is defined.
interface prio_enc_queue_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req_in;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     pending;
  logic             overflow;
`ifdef PRIO_ENC_MASK_EN
  logic [N-1:0]     mask;

  modport master (
    output req_in, out_ready, mask,
    input  out_valid, out_idx, pending, overflow
  );
  modport slave (
    input  req_in, out_ready, mask,
    output out_valid, out_idx, pending, overflow
  );
`else
  modport master (
    output req_in, out_ready,
    input  out_valid, out_idx, pending, overflow
  );
  modport slave (
    input  req_in, out_ready,
    output out_valid, out_idx, pending, overflow
  );
`endif
endinterface

// File: rtl/prio_enc_queue.sv
// Sticky request register presenting the highest pending index over valid/ready, 2 cycles req->valid,
// one index per cycle when ready is held; index frozen under backpressure. Optional mask: PRIO_ENC_MASK_EN.
module prio_enc_queue #(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input logic              clk,
  input logic              rst,
  prio_enc_queue_if.slave  bus
);

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             overflow_q, overflow_d;

  logic             acc;
  logic [N-1:0]     clr_mask;
  logic [N-1:0]     mask_eff;
  logic [N-1:0]     elig_idle;
  logic [N-1:0]     elig_acc;

  function automatic logic [IDX_W-1:0] msb_sel(input logic [N-1:0] v);
    msb_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) msb_sel = IDX_W'(i);
    end
  endfunction

`ifdef PRIO_ENC_MASK_EN
  assign mask_eff = bus.mask;
`else
  assign mask_eff = '0;
`endif

  assign acc        = (state_q == PRESENT) && bus.out_ready;
  assign clr_mask   = acc ? (N'(1) << out_idx_q) : '0;
  // A new request on the bit being retired this cycle keeps it set.
  assign pending_d  = (pending_q & ~clr_mask) | bus.req_in;
  assign overflow_d = |(bus.req_in & pending_q & ~clr_mask);
  assign elig_idle  = pending_q & ~mask_eff;
  assign elig_acc   = pending_d & ~mask_eff;

  always_comb begin
    state_d   = state_q;
    out_idx_d = out_idx_q;
    case (state_q)
      IDLE: begin
        if (|elig_idle) begin
          state_d   = PRESENT;
          out_idx_d = msb_sel(elig_idle);
        end else begin
          out_idx_d = '0;
        end
      end
      PRESENT: begin
        // Without acceptance the index is held: no preemption, no withdrawal on mask.
        if (acc) begin
          if (|elig_acc) begin
            out_idx_d = msb_sel(elig_acc);
          end else begin
            state_d   = IDLE;
            out_idx_d = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        out_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      out_idx_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_idx_q  <= out_idx_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.out_valid = (state_q == PRESENT);
  assign bus.out_idx   = out_idx_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule
